// File: rtl/reg_bus_arbiter_if.sv
// Purpose: bundles every request, response and slave-side signal of the two-master register-bus arbiter.
// Latency: wiring only, no logic.
// Backpressure: masters see busy/drop, and the slave is never stalled by this interface.
// Modports:
//   slave  - the arbiter's view. It serves both requesting masters and drives the shared slave bus.
//   master - the environment's view. It drives the requests and the slave read response.
interface reg_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();
  // master 0 (UART command master)
  logic          m0_wr_en;
  logic          m0_rd_en;
  logic [3:0]    m0_be;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_busy;
  logic          m0_drop;
  logic          m0_rd_rdy;
  logic [DW-1:0] m0_rdata;
  // master 1 (auxiliary master)
  logic          m1_wr_en;
  logic          m1_rd_en;
  logic [3:0]    m1_be;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_busy;
  logic          m1_drop;
  logic          m1_rd_rdy;
  logic [DW-1:0] m1_rdata;
  // shared slave (register file)
  logic          s_wr_en;
  logic          s_rd_en;
  logic [3:0]    s_be;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_rd_rdy;
  logic [DW-1:0] s_rdata;
  logic          rd_timeout;

  modport slave (
    input  m0_wr_en, m0_rd_en, m0_be, m0_addr, m0_wdata,
    output m0_busy, m0_drop, m0_rd_rdy, m0_rdata,
    input  m1_wr_en, m1_rd_en, m1_be, m1_addr, m1_wdata,
    output m1_busy, m1_drop, m1_rd_rdy, m1_rdata,
    output s_wr_en, s_rd_en, s_be, s_addr, s_wdata,
    input  s_rd_rdy, s_rdata,
    output rd_timeout
  );

  modport master (
    output m0_wr_en, m0_rd_en, m0_be, m0_addr, m0_wdata,
    input  m0_busy, m0_drop, m0_rd_rdy, m0_rdata,
    output m1_wr_en, m1_rd_en, m1_be, m1_addr, m1_wdata,
    input  m1_busy, m1_drop, m1_rd_rdy, m1_rdata,
    input  s_wr_en, s_rd_en, s_be, s_addr, s_wdata,
    output s_rd_rdy, s_rdata,
    input  rd_timeout
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Purpose: round-robin arbiter that lets two masters, each with a one-deep request slot, share one register slave.
// Latency: a request pulse in cycle t gives busy in t+1 and the slave strobe in t+2. Read data returns one cycle after s_rd_rdy.
// Backpressure: none toward the slave. A request arriving while its slot is full is ignored and drop pulses.
// Ports: clk, rstb (synchronous, active-low), bus (reg_bus_arbiter_if.slave).
//   The interface carries m0_*/m1_* requests and responses, the s_* slave bus and the rd_timeout pulse.
module reg_bus_arbiter #(
  parameter int            AW           = 16,
  parameter int            DW           = 32,
  parameter int            RD_TIMEOUT   = 255,
  parameter logic [DW-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input logic              clk,
  input logic              rstb,
  reg_bus_arbiter_if.slave bus
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WR, RD, RWAIT} state_t;

  state_t state, state_nxt;

  // Per-port request inputs gathered into arrays so both slots share one capture loop.
  logic [1:0]    req_wr;
  logic [1:0]    req_rd;
  logic [3:0]    req_be    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];

  logic [1:0]    pending;
  logic [1:0]    slot_wr;
  logic [3:0]    slot_be    [2];
  logic [AW-1:0] slot_addr  [2];
  logic [DW-1:0] slot_wdata [2];

  logic          last_grant;
  logic          cur;          // port owning the transaction in flight
  logic          grant_vld;
  logic          grant_idx;
  logic          wr_strobe;
  logic          rd_strobe;
  logic          rd_done;
  logic          rd_expired;
  logic [CW-1:0] cnt;
  logic          timeout_hit;

  logic [1:0]    drop;
  logic [1:0]    rd_rdy;
  logic [DW-1:0] rdata [2];
  logic          timeout_pulse;
  logic [3:0]    s_be;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;

  assign req_wr       = {bus.m1_wr_en, bus.m0_wr_en};
  assign req_rd       = {bus.m1_rd_en, bus.m0_rd_en};
  assign req_be[0]    = bus.m0_be;
  assign req_be[1]    = bus.m1_be;
  assign req_addr[0]  = bus.m0_addr;
  assign req_addr[1]  = bus.m1_addr;
  assign req_wdata[0] = bus.m0_wdata;
  assign req_wdata[1] = bus.m1_wdata;

  // The counter is 0 in the RD cycle, so the RD_TIMEOUT-th read cycle holds RD_TIMEOUT-1.
  assign timeout_hit = (cnt == CW'(RD_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_vld  = 1'b0;
    grant_idx  = last_grant;
    wr_strobe  = 1'b0;
    rd_strobe  = 1'b0;
    rd_done    = 1'b0;
    rd_expired = 1'b0;
    case (state)
      IDLE: begin
        if (pending != 2'b00) begin
          grant_vld = 1'b1;
          // On a tie, grant the port that did not win last time.
          if (pending == 2'b11) grant_idx = ~last_grant;
          else                  grant_idx = pending[1];
          state_nxt = slot_wr[grant_idx] ? WR : RD;
        end
      end
      WR: begin
        wr_strobe = 1'b1;
        state_nxt = IDLE;
      end
      RD, RWAIT: begin
        rd_strobe = (state == RD);
        // Real data takes priority over a timeout that lands in the same cycle.
        if (bus.s_rd_rdy) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          rd_done    = 1'b1;
          rd_expired = 1'b1;
          state_nxt  = IDLE;
        end else begin
          state_nxt = RWAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      pending       <= '0;
      slot_wr       <= '0;
      last_grant    <= 1'b1;
      cur           <= 1'b0;
      cnt           <= '0;
      drop          <= '0;
      rd_rdy        <= '0;
      timeout_pulse <= 1'b0;
      s_be          <= '0;
      s_addr        <= '0;
      s_wdata       <= '0;
      for (int i = 0; i < 2; i++) begin
        slot_be[i]    <= '0;
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
        rdata[i]      <= '0;
      end
    end else begin
      drop          <= '0;
      rd_rdy        <= '0;
      timeout_pulse <= 1'b0;

      for (int i = 0; i < 2; i++) begin
        if (req_wr[i] | req_rd[i]) begin
          if (pending[i]) begin
            drop[i] <= 1'b1;
          end else begin
            // When both strobes arrive together, the write wins and the read is reported as dropped.
            pending[i]    <= 1'b1;
            slot_wr[i]    <= req_wr[i];
            slot_be[i]    <= req_be[i];
            slot_addr[i]  <= req_addr[i];
            slot_wdata[i] <= req_wdata[i];
            drop[i]       <= req_wr[i] & req_rd[i];
          end
        end
      end

      if (grant_vld) begin
        cur        <= grant_idx;
        last_grant <= grant_idx;
        s_be       <= slot_be[grant_idx];
        s_addr     <= slot_addr[grant_idx];
        s_wdata    <= slot_wdata[grant_idx];
      end

      if (wr_strobe) pending[cur] <= 1'b0;

      if (rd_done) begin
        pending[cur]  <= 1'b0;
        rd_rdy[cur]   <= 1'b1;
        rdata[cur]    <= rd_expired ? TIMEOUT_DATA : bus.s_rdata;
        timeout_pulse <= rd_expired;
      end

      if (state == RD || state == RWAIT) cnt <= cnt + CW'(1);
      else                               cnt <= '0;
    end
  end

  assign bus.m0_busy    = pending[0];
  assign bus.m1_busy    = pending[1];
  assign bus.m0_drop    = drop[0];
  assign bus.m1_drop    = drop[1];
  assign bus.m0_rd_rdy  = rd_rdy[0];
  assign bus.m1_rd_rdy  = rd_rdy[1];
  assign bus.m0_rdata   = rdata[0];
  assign bus.m1_rdata   = rdata[1];
  assign bus.s_wr_en    = wr_strobe;
  assign bus.s_rd_en    = rd_strobe;
  assign bus.s_be       = s_be;
  assign bus.s_addr     = s_addr;
  assign bus.s_wdata    = s_wdata;
  assign bus.rd_timeout = timeout_pulse;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Purpose: directed bench for reg_bus_arbiter. It covers writes, reads, round-robin ties, drops, timeout and mid-read reset.
// Latency: inputs are driven and outputs sampled on the falling edge, half a cycle away from the DUT's active edge.
// Backpressure: the slave response is scripted cycle by cycle.
module tb_reg_bus_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int RD_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  reg_bus_arbiter #(
    .AW(AW), .DW(DW), .RD_TIMEOUT(RD_TIMEOUT), .TIMEOUT_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .bus(bus)
  );

  // Slave-side log of the addresses the slave sees for each strobe.
  logic [AW-1:0] wr_q[$];
  logic [AW-1:0] rd_q[$];
  always @(negedge clk) begin
    if (bus.s_wr_en === 1'b1) wr_q.push_back(bus.s_addr);
    if (bus.s_rd_en === 1'b1) rd_q.push_back(bus.s_addr);
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic req(input int port, input logic wr, input logic rd, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [3:0] be);
    if (port == 0) begin
      bus.m0_wr_en = wr; bus.m0_rd_en = rd; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_be = be;
    end else begin
      bus.m1_wr_en = wr; bus.m1_rd_en = rd; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_be = be;
    end
  endtask

  task automatic idle_req();
    bus.m0_wr_en = 1'b0; bus.m0_rd_en = 1'b0;
    bus.m1_wr_en = 1'b0; bus.m1_rd_en = 1'b0;
  endtask

  initial begin
    idle_req();
    bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be = '0;
    bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be = '0;
    bus.s_rd_rdy = 1'b0; bus.s_rdata = '0;

    // Reset state
    repeat (3) step();
    chk("rst_m0_busy", bus.m0_busy, 0);
    chk("rst_m1_busy", bus.m1_busy, 0);
    chk("rst_s_wr_en", bus.s_wr_en, 0);
    chk("rst_s_rd_en", bus.s_rd_en, 0);
    chk("rst_m0_rdata", bus.m0_rdata, 0);
    chk("rst_s_addr", bus.s_addr, 0);
    chk("rst_rd_timeout", bus.rd_timeout, 0);
    chk("rst_m0_drop", bus.m0_drop, 0);
    rstb = 1'b1;
    step();

    // m0 single write
    req(0, 1'b1, 1'b0, 16'h0004, 32'h0000_00A5, 4'b0001);
    step(); idle_req();
    chk("wr_busy_t1", bus.m0_busy, 1);
    chk("wr_s_wr_en_t1", bus.s_wr_en, 0);
    chk("wr_drop_t1", bus.m0_drop, 0);
    step();
    chk("wr_s_wr_en_t2", bus.s_wr_en, 1);
    chk("wr_s_addr", bus.s_addr, 32'h0004);
    chk("wr_s_wdata", bus.s_wdata, 32'h0000_00A5);
    chk("wr_s_be", bus.s_be, 4'b0001);
    chk("wr_busy_t2", bus.m0_busy, 1);
    step();
    chk("wr_s_wr_en_t3", bus.s_wr_en, 0);
    chk("wr_busy_t3", bus.m0_busy, 0);
    chk("wr_count", wr_q.size(), 1);

    // m1 read, slave answers three cycles after s_rd_en
    req(1, 1'b0, 1'b1, 16'h0008, 32'h0, 4'hF);
    step(); idle_req();
    chk("rd_m1_busy", bus.m1_busy, 1);
    step();
    chk("rd_s_rd_en", bus.s_rd_en, 1);
    chk("rd_s_addr", bus.s_addr, 32'h0008);
    step();
    chk("rd_s_rd_en_low", bus.s_rd_en, 0);
    step();
    step();
    chk("rd_m1_rd_rdy_early", bus.m1_rd_rdy, 0);
    bus.s_rd_rdy = 1'b1; bus.s_rdata = 32'h1234_5678;
    step(); bus.s_rd_rdy = 1'b0; bus.s_rdata = 32'h0;
    chk("rd_m1_rd_rdy", bus.m1_rd_rdy, 1);
    chk("rd_m1_rdata", bus.m1_rdata, 32'h1234_5678);
    chk("rd_m0_rd_rdy", bus.m0_rd_rdy, 0);
    chk("rd_m1_busy_done", bus.m1_busy, 0);
    chk("rd_no_timeout", bus.rd_timeout, 0);
    step();
    chk("rd_m1_rd_rdy_pulse", bus.m1_rd_rdy, 0);
    chk("rd_m1_rdata_hold", bus.m1_rdata, 32'h1234_5678);

    // Simultaneous writes, four rounds
    for (int i = 0; i < 4; i++) begin
      req(0, 1'b1, 1'b0, AW'(16'h0100 + i), 32'h0, 4'hF);
      req(1, 1'b1, 1'b0, AW'(16'h0200 + i), 32'h0, 4'hF);
      step(); idle_req();
      chk("pair_m0_drop", bus.m0_drop, 0);
      chk("pair_m1_drop", bus.m1_drop, 0);
      repeat (4) step();
    end
    chk("pair_count", wr_q.size(), 9);
    for (int i = 0; i < 4; i++) begin
      chk("pair_order_m0", wr_q[1 + 2 * i], AW'(16'h0100 + i));
      chk("pair_order_m1", wr_q[2 + 2 * i], AW'(16'h0200 + i));
    end

    // Tie right after an m0 grant: m1 must win
    req(0, 1'b1, 1'b0, 16'h0300, 32'h0, 4'hF);
    step(); idle_req();
    step();
    step();
    req(0, 1'b1, 1'b0, 16'h0301, 32'h0, 4'hF);
    req(1, 1'b1, 1'b0, 16'h0400, 32'h0, 4'hF);
    step(); idle_req();
    chk("tie_m0_drop", bus.m0_drop, 0);
    chk("tie_m1_drop", bus.m1_drop, 0);
    repeat (4) step();
    chk("tie_count", wr_q.size(), 12);
    chk("tie_order_0", wr_q[9], 16'h0300);
    chk("tie_order_1", wr_q[10], 16'h0400);
    chk("tie_order_2", wr_q[11], 16'h0301);

    // Drops: request while busy, then dual strobe once free
    req(0, 1'b0, 1'b1, 16'h0010, 32'h0, 4'hF);
    step(); idle_req();
    chk("drop_first_ok", bus.m0_drop, 0);
    chk("drop_busy", bus.m0_busy, 1);
    req(0, 1'b1, 1'b0, 16'h0020, 32'h0, 4'hF);
    step(); idle_req();
    chk("drop_while_busy", bus.m0_drop, 1);
    chk("drop_s_rd_en", bus.s_rd_en, 1);
    chk("drop_s_addr", bus.s_addr, 32'h0010);
    step();
    chk("drop_pulse_len", bus.m0_drop, 0);
    bus.s_rd_rdy = 1'b1; bus.s_rdata = 32'hCAFE_0001;
    step(); bus.s_rd_rdy = 1'b0; bus.s_rdata = 32'h0;
    chk("drop_rd_rdy", bus.m0_rd_rdy, 1);
    chk("drop_rdata", bus.m0_rdata, 32'hCAFE_0001);
    chk("drop_busy_free", bus.m0_busy, 0);
    req(0, 1'b1, 1'b1, 16'h0030, 32'h0000_0055, 4'hF);
    step(); idle_req();
    chk("dual_drop", bus.m0_drop, 1);
    chk("dual_busy", bus.m0_busy, 1);
    step();
    chk("dual_s_wr_en", bus.s_wr_en, 1);
    chk("dual_s_rd_en", bus.s_rd_en, 0);
    chk("dual_s_addr", bus.s_addr, 32'h0030);
    chk("dual_s_wdata", bus.s_wdata, 32'h0000_0055);
    step();
    chk("dual_busy_free", bus.m0_busy, 0);
    chk("drop_wr_count", wr_q.size(), 13);
    chk("drop_rd_count", rd_q.size(), 2);
    chk("drop_rd_addr", rd_q[1], 16'h0010);

    // Timeout: slave never answers
    req(0, 1'b0, 1'b1, 16'h0040, 32'h0, 4'hF);
    step(); idle_req();
    step();
    chk("to_s_rd_en", bus.s_rd_en, 1);
    for (int k = 1; k < RD_TIMEOUT; k++) begin
      step();
      chk("to_wait_rd_rdy", bus.m0_rd_rdy, 0);
      chk("to_wait_timeout", bus.rd_timeout, 0);
    end
    step();
    chk("to_rd_rdy", bus.m0_rd_rdy, 1);
    chk("to_pulse", bus.rd_timeout, 1);
    chk("to_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    chk("to_busy", bus.m0_busy, 0);
    bus.s_rd_rdy = 1'b1; bus.s_rdata = 32'h1111_1111;
    step(); bus.s_rd_rdy = 1'b0; bus.s_rdata = 32'h0;
    chk("late_m0_rd_rdy", bus.m0_rd_rdy, 0);
    chk("late_m1_rd_rdy", bus.m1_rd_rdy, 0);
    chk("late_timeout", bus.rd_timeout, 0);
    chk("late_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    step();

    // Data arriving in the timeout cycle wins
    req(1, 1'b0, 1'b1, 16'h0044, 32'h0, 4'hF);
    step(); idle_req();
    step();
    chk("edge_s_rd_en", bus.s_rd_en, 1);
    repeat (RD_TIMEOUT - 1) step();
    bus.s_rd_rdy = 1'b1; bus.s_rdata = 32'h0000_0077;
    step(); bus.s_rd_rdy = 1'b0; bus.s_rdata = 32'h0;
    chk("edge_rd_rdy", bus.m1_rd_rdy, 1);
    chk("edge_rdata", bus.m1_rdata, 32'h0000_0077);
    chk("edge_no_timeout", bus.rd_timeout, 0);
    step();

    // Reset during RWAIT
    req(0, 1'b0, 1'b1, 16'h0050, 32'h0, 4'hF);
    step(); idle_req();
    step();
    chk("rw_s_rd_en", bus.s_rd_en, 1);
    step();
    step();
    chk("rw_busy", bus.m0_busy, 1);
    chk("rw_s_rd_en_low", bus.s_rd_en, 0);
    rstb = 1'b0;
    step(); rstb = 1'b1;
    chk("rw_rst_busy", bus.m0_busy, 0);
    chk("rw_rst_s_rd_en", bus.s_rd_en, 0);
    chk("rw_rst_s_wr_en", bus.s_wr_en, 0);
    chk("rw_rst_m0_rdata", bus.m0_rdata, 0);
    chk("rw_rst_m1_rdata", bus.m1_rdata, 0);
    chk("rw_rst_s_addr", bus.s_addr, 0);
    chk("rw_rst_rd_rdy", bus.m0_rd_rdy, 0);
    chk("rw_rst_timeout", bus.rd_timeout, 0);
    bus.s_rd_rdy = 1'b1; bus.s_rdata = 32'h0000_0099;
    step(); bus.s_rd_rdy = 1'b0; bus.s_rdata = 32'h0;
    chk("rw_stray_rd_rdy", bus.m0_rd_rdy, 0);
    chk("rw_stray_rdata", bus.m0_rdata, 0);
    chk("rw_stray_busy", bus.m0_busy, 0);
    req(0, 1'b0, 1'b1, 16'h0060, 32'h0, 4'hF);
    step(); idle_req();
    step();
    chk("rw_new_s_rd_en", bus.s_rd_en, 1);
    chk("rw_new_s_addr", bus.s_addr, 32'h0060);
    bus.s_rd_rdy = 1'b1; bus.s_rdata = 32'h0000_ABCD;
    step(); bus.s_rd_rdy = 1'b0; bus.s_rdata = 32'h0;
    chk("rw_new_rd_rdy", bus.m0_rd_rdy, 1);
    chk("rw_new_rdata", bus.m0_rdata, 32'h0000_ABCD);
    chk("rw_new_busy", bus.m0_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
